vga_pixel_fetch: RTL and testbench

Prefetch stage between the board SRAM (IS61WV102416, 1M×16, asynchronous) and the VGA timing generator. Streams one RGB565 frame per `i_frame_start` from SRAM into a small show-ahead FIFO. The VGA stage pops one pixel per active-area clock from this FIFO and drives its `i_display_data` from `o_pix_data`. The block owns the SRAM read bus while fetching and releases it otherwise.

---
 rtl/vga_pixel_fetch.sv | 274 +++++++++++++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// -----------------------------------------------------------------------------
// vga_pixel_fetch
//
// Prefetch stage between the board SRAM (IS61WV102416, 1M x 16, asynchronous)
// and the VGA timing generator. Every i_frame_start streams one RGB565 frame
// (FRAME_PIXELS words from i_base_addr upward) from SRAM into a small
// show-ahead FIFO. The VGA stage pops one pixel per active-area clock.
//
// Optional feature macro: PIXFETCH_TESTPATTERN_EN
//   Defined   : i_test_mode=1 replaces SRAM reads with an internal colour-bar
//               pattern (8 bars of 80 pixels per 640-pixel line). The SRAM
//               strobes stay deasserted. The fill rate and latency are the
//               same as for SRAM reads.
//   Undefined : i_test_mode is ignored and SRAM is always the source.
//
// Parameters
//   FIFO_DEPTH    FIFO entries (power of two, >= 4)
//   FRAME_PIXELS  words fetched per frame
//
// Ports
//   i_25M_clk      pixel clock
//   i_rst_n        asynchronous, active-low reset
//   i_frame_start  one-cycle pulse at start of vertical blank
//   i_base_addr    frame base word address, sampled on i_frame_start
//   i_pix_req      VGA pops the head pixel this cycle
//   i_test_mode    pattern-source select (feature macro only)
//   o_pix_data     FIFO head (RGB565), 0 when the FIFO is empty
//   o_pix_valid    FIFO non-empty
//   o_underflow    sticky: a pop was attempted while empty (reset clears it)
//   o_busy         high while fetching (S_FETCH)
//   o_dbg_state    FSM state: 0 S_IDLE, 1 S_FETCH, 2 S_DONE
//   o_SRAM_ADDR    SRAM read address
//   i_SRAM_DQ      SRAM read data
//   o_SRAM_*_N     SRAM strobes, active-low
//
// Handshake (o_pix_valid / i_pix_req): a pixel is consumed on a rising edge
// where both are high. The next head is visible in the following cycle.
// i_pix_req with o_pix_valid low moves nothing and sets o_underflow.
// -----------------------------------------------------------------------------
module vga_pixel_fetch #(
   parameter int FIFO_DEPTH   = 16,
   parameter int FRAME_PIXELS = 307200
) (
   input  logic        i_25M_clk,
   input  logic        i_rst_n,
   input  logic        i_frame_start,
   input  logic [19:0] i_base_addr,
   input  logic        i_pix_req,
   input  logic        i_test_mode,
   output logic [15:0] o_pix_data,
   output logic        o_pix_valid,
   output logic        o_underflow,
   output logic        o_busy,
   output logic [1:0]  o_dbg_state,
   output logic [19:0] o_SRAM_ADDR,
   input  logic [15:0] i_SRAM_DQ,
   output logic        o_SRAM_CE_N,
   output logic        o_SRAM_OE_N,
   output logic        o_SRAM_WE_N,
   output logic        o_SRAM_LB_N,
   output logic        o_SRAM_UB_N
);

   localparam int          PTR_W      = $clog2(FIFO_DEPTH);
   localparam int          CNT_W      = PTR_W + 1;
   localparam logic [18:0] FRAME_LAST = 19'(FRAME_PIXELS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t state_q, state_d;

   // rd_q: a read is on the bus this cycle; its data lands in the FIFO at
   // the next edge. This is the only in-flight read, so inflight == rd_q.
   logic        rd_q, rd_d;
   logic [19:0] addr_q, addr_d;
   logic [19:0] next_addr_q, next_addr_d;
   logic [18:0] issued_q, issued_d;
   logic        strobe_n_q;
   logic        rd_sram_d;

   // FIFO storage and bookkeeping
   logic [15:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             fifo_valid;
   logic             push, pop;
   logic [15:0]      wr_data;

   logic underflow_q, underflow_d;

   assign fifo_valid = (count_q != '0);

   // -------------------------------------------------------------------------
   // FSM, read issue and FIFO bookkeeping (next-state logic)
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      rd_d        = 1'b0;
      addr_d      = addr_q;
      next_addr_d = next_addr_q;
      issued_d    = issued_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      push        = 1'b0;
      pop         = 1'b0;
      underflow_d = underflow_q | (i_pix_req & ~fifo_valid);

      if (i_frame_start) begin
         // Restart from any state: flush the FIFO, drop the in-flight read
         // and schedule the first read of the new frame for the next cycle.
         state_d     = S_FETCH;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         rd_d        = (FRAME_LAST != 19'd0);
         addr_d      = i_base_addr;
         next_addr_d = i_base_addr + 20'd1;
         issued_d    = (FRAME_LAST != 19'd0) ? 19'd1 : 19'd0;
      end else begin
         push = rd_q;
         pop  = i_pix_req & fifo_valid;
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);

         case (state_q)
            S_FETCH: begin
               if (rd_q && (issued_q == FRAME_LAST)) begin
                  // The last read of the frame lands at this edge.
                  state_d = S_DONE;
               end else if ((issued_q < FRAME_LAST) &&
                            ((count_q + CNT_W'(rd_q)) < CNT_W'(FIFO_DEPTH))) begin
                  // Counting the in-flight read as occupied guarantees the
                  // FIFO can never be pushed while full.
                  rd_d        = 1'b1;
                  addr_d      = next_addr_q;
                  next_addr_d = next_addr_q + 20'd1;
                  issued_d    = issued_q + 19'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Pattern source
   // -------------------------------------------------------------------------
`ifdef PIXFETCH_TESTPATTERN_EN
   // bar/sub track the index of the next read: bar = (idx % 640) / 80,
   // sub = idx % 80. Its colour is registered alongside the read so the
   // push path matches the SRAM path cycle for cycle.
   logic        pat_src_q, pat_src_d;
   logic [2:0]  bar_q, bar_d, bar_cur;
   logic [6:0]  sub_q, sub_d, sub_cur;
   logic [15:0] pat_word_q, pat_word_d;

   function automatic logic [15:0] bar_colour(input logic [2:0] bar);
      logic [15:0] c;
      case (bar)
         3'd0:    c = 16'hFFFF;
         3'd1:    c = 16'hFFE0;
         3'd2:    c = 16'h07FF;
         3'd3:    c = 16'h07E0;
         3'd4:    c = 16'hF81F;
         3'd5:    c = 16'hF800;
         3'd6:    c = 16'h001F;
         default: c = 16'h0000;
      endcase
      return c;
   endfunction

   always_comb begin
      bar_cur    = i_frame_start ? 3'd0 : bar_q;
      sub_cur    = i_frame_start ? 7'd0 : sub_q;
      bar_d      = bar_q;
      sub_d      = sub_q;
      pat_word_d = pat_word_q;
      pat_src_d  = rd_d & i_test_mode;
      if (rd_d) begin
         pat_word_d = bar_colour(bar_cur);
         if (sub_cur == 7'd79) begin
            sub_d = 7'd0;
            bar_d = bar_cur + 3'd1;   // 8 bars per line, wraps at 640
         end else begin
            sub_d = sub_cur + 7'd1;
            bar_d = bar_cur;
         end
      end
   end

   always_ff @(posedge i_25M_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pat_src_q  <= 1'b0;
         bar_q      <= 3'd0;
         sub_q      <= 7'd0;
         pat_word_q <= 16'h0000;
      end else begin
         pat_src_q  <= pat_src_d;
         bar_q      <= bar_d;
         sub_q      <= sub_d;
         pat_word_q <= pat_word_d;
      end
   end

   assign rd_sram_d = rd_d & ~pat_src_d;
   assign wr_data   = pat_src_q ? pat_word_q : i_SRAM_DQ;
`else
   logic unused_test_mode;
   assign unused_test_mode = i_test_mode;
   assign rd_sram_d        = rd_d;
   assign wr_data          = i_SRAM_DQ;
`endif

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge i_25M_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         rd_q        <= 1'b0;
         addr_q      <= 20'd0;
         next_addr_q <= 20'd0;
         issued_q    <= 19'd0;
         strobe_n_q  <= 1'b1;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         addr_q      <= addr_d;
         next_addr_q <= next_addr_d;
         issued_q    <= issued_d;
         strobe_n_q  <= ~rd_sram_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         underflow_q <= underflow_d;
      end
   end

   // FIFO storage needs no reset: count_q gates everything read from it.
   always_ff @(posedge i_25M_clk) begin
      if (push) fifo_mem[wr_ptr_q] <= wr_data;
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // The head mux reads registers only; an empty FIFO shows black.
   assign o_pix_data  = fifo_valid ? fifo_mem[rd_ptr_q] : 16'h0000;
   assign o_pix_valid = fifo_valid;
   assign o_underflow = underflow_q;
   assign o_busy      = (state_q == S_FETCH);
   assign o_dbg_state = state_q;

   // All read strobes come from one flop, so they cannot glitch low and
   // they return high asynchronously on reset.
   assign o_SRAM_ADDR = addr_q;
   assign o_SRAM_CE_N = strobe_n_q;
   assign o_SRAM_OE_N = strobe_n_q;
   assign o_SRAM_LB_N = strobe_n_q;
   assign o_SRAM_UB_N = strobe_n_q;
   assign o_SRAM_WE_N = 1'b1;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_vga_pixel_fetch
//
// Bench for vga_pixel_fetch with a short frame (1280 words) so that whole
// frames fit in a short run. The SRAM model returns addr[15:0] while it is
// read, and 16'hDEAD otherwise. A behavioural model rebuilds the full
// expected pixel sequence of a frame at every frame start. The monitor
// compares the FIFO head and every issued read address against it on each
// cycle. Directed sequences pin the latencies, boundaries and literals.
// -----------------------------------------------------------------------------
module tb_vga_pixel_fetch;

   localparam int F     = 1280;
   localparam int DEPTH = 16;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #20 clk = ~clk;

   // ---------------------------------------------------------------- DUT
   logic        i_frame_start = 1'b0;
   logic [19:0] i_base_addr   = 20'd0;
   logic        i_pix_req     = 1'b0;
   logic        i_test_mode   = 1'b0;
   logic [15:0] o_pix_data;
   logic        o_pix_valid, o_underflow, o_busy;
   logic [1:0]  o_dbg_state;
   logic [19:0] o_SRAM_ADDR;
   logic [15:0] sram_dq;
   logic        o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N;

   vga_pixel_fetch #(.FIFO_DEPTH(DEPTH), .FRAME_PIXELS(F)) dut (
      .i_25M_clk     (clk),
      .i_rst_n       (rst_n),
      .i_frame_start (i_frame_start),
      .i_base_addr   (i_base_addr),
      .i_pix_req     (i_pix_req),
      .i_test_mode   (i_test_mode),
      .o_pix_data    (o_pix_data),
      .o_pix_valid   (o_pix_valid),
      .o_underflow   (o_underflow),
      .o_busy        (o_busy),
      .o_dbg_state   (o_dbg_state),
      .o_SRAM_ADDR   (o_SRAM_ADDR),
      .i_SRAM_DQ     (sram_dq),
      .o_SRAM_CE_N   (o_SRAM_CE_N),
      .o_SRAM_OE_N   (o_SRAM_OE_N),
      .o_SRAM_WE_N   (o_SRAM_WE_N),
      .o_SRAM_LB_N   (o_SRAM_LB_N),
      .o_SRAM_UB_N   (o_SRAM_UB_N)
   );

   // SRAM model: data = address while a read is actually strobed.
   assign sram_dq = (!o_SRAM_CE_N && !o_SRAM_OE_N) ? o_SRAM_ADDR[15:0] : 16'hDEAD;

   // ---------------------------------------------------------------- scoreboard
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] bar_colour(input int idx);
      logic [15:0] tbl [8];
      tbl = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
      return tbl[(idx % 640) / 80];
   endfunction

   logic [15:0] exp_q[$];
   logic [19:0] addr_exp = 20'd0;
   int          n_reads  = 0;
   int          n_pops   = 0;
   logic [19:0] rd_log  [4];
   logic [15:0] pop_log [F];

   // Monitor: compare first, then advance the model for this cycle's edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         n_reads = 0;
         n_pops  = 0;
      end else begin
         if (o_pix_valid) begin
            if (exp_q.size() == 0) check("fifo_extra_word", 0, 1);
            else                   check("pix_head", o_pix_data, exp_q[0]);
         end else begin
            check("pix_data_empty", o_pix_data, 16'h0000);
         end
         if (!o_SRAM_OE_N) begin
            check("rd_addr", o_SRAM_ADDR, addr_exp);
            check("rd_ce_n", o_SRAM_CE_N, 1'b0);
            check("rd_busy", o_busy, 1'b1);
            check("rd_credit",
                  ((n_reads - n_pops + 1 - int'(i_pix_req && o_pix_valid)) <= DEPTH), 1'b1);
            if (n_reads < 4) rd_log[n_reads] = o_SRAM_ADDR;
            addr_exp = addr_exp + 20'd1;
            n_reads++;
         end
         if (i_frame_start) begin
            exp_q.delete();
            for (int i = 0; i < F; i++) begin
`ifdef PIXFETCH_TESTPATTERN_EN
               if (i_test_mode) exp_q.push_back(bar_colour(i));
               else             exp_q.push_back(16'(i_base_addr + 20'(i)));
`else
               exp_q.push_back(16'(i_base_addr + 20'(i)));
`endif
            end
            addr_exp = i_base_addr;
            n_reads  = 0;
            n_pops   = 0;
         end else if (i_pix_req && o_pix_valid) begin
            if (n_pops < F) pop_log[n_pops] = o_pix_data;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n_pops++;
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   // Returns one #1 into cycle t+1, where t is the pulse cycle.
   task automatic frame_pulse(input logic [19:0] base);
      @(posedge clk); #1;
      i_frame_start = 1'b1;
      i_base_addr   = base;
      @(posedge clk); #1;
      i_frame_start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pix_data"},  o_pix_data, 16'h0000);
      check({tag, "_pix_valid"}, o_pix_valid, 1'b0);
      check({tag, "_underflow"}, o_underflow, 1'b0);
      check({tag, "_busy"},      o_busy, 1'b0);
      check({tag, "_state"},     o_dbg_state, 2'd0);
      check({tag, "_addr"},      o_SRAM_ADDR, 20'd0);
      check({tag, "_strobes"},
            {o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N}, 5'b11111);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int gaps;
      int oe_low;

      // Reset, then 10 idle cycles
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("idle");

      // Fill without pops: 16 reads from 0x00100, then stall
      frame_pulse(20'h00100);
      @(negedge clk);
      check("t1_oe_n", o_SRAM_OE_N, 1'b0);
      check("t1_addr", o_SRAM_ADDR, 20'h00100);
      check("t1_valid", o_pix_valid, 1'b0);
      check("t1_busy", o_busy, 1'b1);
      @(negedge clk);
      check("t2_valid", o_pix_valid, 1'b1);
      check("t2_head", o_pix_data, 16'h0100);
      repeat (30) @(negedge clk);
      #1;
      check("fill_reads", n_reads, 16);
      check("fill_last_addr", o_SRAM_ADDR, 20'h0010F);
      check("fill_oe_n_stall", o_SRAM_OE_N, 1'b1);
      check("fill_head", o_pix_data, 16'h0100);
      check("fill_state", o_dbg_state, 2'd1);

      // Full-frame stream: pop every cycle from t+2
      frame_pulse(20'h00100);
      @(posedge clk); #1;
      i_pix_req = 1'b1;
      gaps = 0;
      for (int i = 0; i < F; i++) begin
         @(negedge clk);
         if (!o_pix_valid) gaps++;
         if (i == 0) check("stream_pix0", o_pix_data, 16'h0100);
         if (i == 2) check("stream_pix2", o_pix_data, 16'h0102);
      end
      @(posedge clk); #1;
      i_pix_req = 1'b0;
      @(negedge clk); #1;
      check("stream_gaps", gaps, 0);
      check("stream_pops", n_pops, F);
      check("stream_state_done", o_dbg_state, 2'd2);
      check("stream_busy", o_busy, 1'b0);
      check("stream_underflow", o_underflow, 1'b0);
      check("stream_drained", exp_q.size(), 0);
      check("stream_strobes_off", {o_SRAM_CE_N, o_SRAM_OE_N}, 2'b11);

      // Address wrap at the top of SRAM
      frame_pulse(20'hFFFFE);
      repeat (10) @(negedge clk);
      #1;
      check("wrap_addr0", rd_log[0], 20'hFFFFE);
      check("wrap_addr1", rd_log[1], 20'hFFFFF);
      check("wrap_addr2", rd_log[2], 20'h00000);
      check("wrap_addr3", rd_log[3], 20'h00001);
      check("wrap_head", o_pix_data, 16'hFFFE);

      // Pop while empty right after frame start
      frame_pulse(20'h00200);
      i_pix_req = 1'b1;
      @(negedge clk);
      check("uf_data_black", o_pix_data, 16'h0000);
      check("uf_valid", o_pix_valid, 1'b0);
      @(posedge clk); #1;
      i_pix_req = 1'b0;
      @(negedge clk);
      check("uf_set", o_underflow, 1'b1);
      check("uf_fifo_kept", o_pix_data, 16'h0200);
      repeat (20) @(negedge clk);
      check("uf_sticky", o_underflow, 1'b1);

      // Frame start while reads are still in flight, then bursty pops
      frame_pulse(20'h00300);
      repeat (3) @(posedge clk);
      frame_pulse(20'h00400);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         i_pix_req = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      i_pix_req = 1'b0;
      @(negedge clk); #1;
      check("restart_first_addr", rd_log[0], 20'h00400);
      check("restart_underflow_sticky", o_underflow, 1'b1);

      // Asynchronous reset in the middle of a fetch
      frame_pulse(20'h00500);
      repeat (3) @(posedge clk);
      #5 rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("postreset");

`ifdef PIXFETCH_TESTPATTERN_EN
      // Colour bars: the SRAM stays untouched
      i_test_mode = 1'b1;
      frame_pulse(20'h00000);
      oe_low = 0;
      @(negedge clk);
      if (!o_SRAM_OE_N) oe_low++;
      @(posedge clk); #1;
      i_pix_req = 1'b1;
      for (int i = 0; i < 640; i++) begin
         @(negedge clk);
         if (!o_SRAM_OE_N) oe_low++;
      end
      @(posedge clk); #1;
      i_pix_req = 1'b0;
      i_test_mode = 1'b0;
      @(negedge clk); #1;
      check("pat_oe_low_cycles", oe_low, 0);
      check("pat_pops", n_pops, 640);
      check("pat_pop0", pop_log[0], 16'hFFFF);
      check("pat_pop79", pop_log[79], 16'hFFFF);
      check("pat_pop80", pop_log[80], 16'hFFE0);
      check("pat_pop159", pop_log[159], 16'hFFE0);
      check("pat_pop160", pop_log[160], 16'h07FF);
      check("pat_pop639", pop_log[639], 16'h0000);
`else
      oe_low = 0;
      if (oe_low != 0) $display("unreachable");
`endif

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
